// File: rtl/user_check_module.sv
// Read-side checker for the DDR/AXI4 loopback path. Each burst is compared against
// an incrementing pattern, and sticky error, timeout and burst statistics are kept.
module user_check_module #(
  parameter int P_RD_LENGTH       = 4096,
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_TIMEOUT         = 65535,
  parameter int P_CNT_WIDTH       = 16
) (
  input  logic                         i_user_rdclk,
  input  logic                         i_rst_n,
  input  logic [P_USER_DATA_WIDTH-1:0] i_user_rd_data,
  input  logic                         i_user_rd_valid,
  input  logic                         i_user_rd_last,
  input  logic                         i_clear,
  output logic                         o_check_busy,
  output logic                         o_burst_done,
  output logic                         o_burst_ok,
  output logic                         o_err_flag,
  output logic                         o_timeout,
  output logic [P_CNT_WIDTH-1:0]       o_err_cnt,
  output logic [P_CNT_WIDTH-1:0]       o_burst_cnt,
  output logic [P_USER_DATA_WIDTH-1:0] o_exp_data
);

  localparam int K_W = $clog2(P_RD_LENGTH);
  localparam int T_W = $clog2(P_TIMEOUT + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CHECK = 1'b1;

  localparam logic [K_W-1:0] K_FINAL  = K_W'(P_RD_LENGTH - 1);
  localparam logic [T_W-1:0] T_EXPIRE = T_W'(P_TIMEOUT - 1);

  logic [0:0]                   state_q, state_d;
  logic [K_W-1:0]               k_q, k_d, k_cur;
  logic [T_W-1:0]               idle_q, idle_d;
  logic                         bad_q, bad_d;
  logic                         busy_q, busy_d;
  logic                         done_q, ok_q;
  logic                         flag_q, flag_d;
  logic                         tout_q, tout_d;
  logic [P_CNT_WIDTH-1:0]       err_cnt_q, err_cnt_d, err_base;
  logic [P_CNT_WIDTH-1:0]       bcnt_q, bcnt_d, bcnt_base;
  logic [P_USER_DATA_WIDTH-1:0] exp_q, exp_d, exp_cur;

  logic is_final, beat_err, end_beat, timeout_evt, err_evt, done_evt, burst_bad;

  // Pattern value for a beat index: the index modulo 2^P_USER_DATA_WIDTH.
  function automatic logic [P_USER_DATA_WIDTH-1:0] pattern(input logic [K_W-1:0] k);
    return P_USER_DATA_WIDTH'(k);
  endfunction

  always_comb begin
    k_cur       = (state_q == S_CHECK) ? k_q : '0;
    exp_cur     = pattern(k_cur);
    is_final    = (k_cur == K_FINAL);
    // A beat with several faults still counts as one error.
    beat_err    = i_user_rd_valid &
                  ((i_user_rd_data != exp_cur) | (i_user_rd_last != is_final));
    end_beat    = i_user_rd_valid & (i_user_rd_last | is_final);
    timeout_evt = (state_q == S_CHECK) & ~i_user_rd_valid & (idle_q == T_EXPIRE);
    err_evt     = beat_err | timeout_evt;
    done_evt    = end_beat | timeout_evt;
    burst_bad   = ((state_q == S_CHECK) & bad_q) | err_evt;

    state_d = state_q;
    k_d     = k_q;
    if (done_evt) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else if (i_user_rd_valid) begin
      state_d = S_CHECK;
      k_d     = k_cur + 1'b1;
    end

    idle_d = ((state_q == S_CHECK) && !i_user_rd_valid && !timeout_evt) ?
             idle_q + 1'b1 : '0;
    bad_d  = done_evt ? 1'b0 : burst_bad;
    busy_d = (state_d == S_CHECK);
    exp_d  = pattern(k_d);

    // Clear takes effect first, so an event in the same cycle lands on zeroed stats.
    err_base  = i_clear ? '0 : err_cnt_q;
    bcnt_base = i_clear ? '0 : bcnt_q;
    err_cnt_d = (err_evt && (err_base != '1)) ? err_base + 1'b1 : err_base;
    bcnt_d    = done_evt ? bcnt_base + 1'b1 : bcnt_base;
    flag_d    = (flag_q & ~i_clear) | err_evt;
    tout_d    = (tout_q & ~i_clear) | timeout_evt;
  end

  always_ff @(posedge i_user_rdclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      idle_q    <= '0;
      bad_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      flag_q    <= 1'b0;
      tout_q    <= 1'b0;
      err_cnt_q <= '0;
      bcnt_q    <= '0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      idle_q    <= idle_d;
      bad_q     <= bad_d;
      busy_q    <= busy_d;
      done_q    <= done_evt;
      ok_q      <= done_evt & ~burst_bad;
      flag_q    <= flag_d;
      tout_q    <= tout_d;
      err_cnt_q <= err_cnt_d;
      bcnt_q    <= bcnt_d;
      exp_q     <= exp_d;
    end
  end

  assign o_check_busy = busy_q;
  assign o_burst_done = done_q;
  assign o_burst_ok   = ok_q;
  assign o_err_flag   = flag_q;
  assign o_timeout    = tout_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_burst_cnt  = bcnt_q;
  assign o_exp_data   = exp_q;

endmodule
